// File: rtl/sm_para_drv.sv
// -----------------------------------------------------------------------------
// sm_para_drv -- in-system stimulus driver for the two-input control FSMs.
//
// A small table of {hold, i1, i2} entries is loaded while idle and then played
// into the FSM under test. Each entry is held for hold+1 cycles, and playback
// optionally wraps from the last entry back to entry 0. While playing, the
// FSM's err output is counted per cycle and rising edges of its o1 output are
// counted. Both counters saturate.
//
// Build option: define SM_PARA_DRV_ERR_ABORT_EN to make a sampled err abort
// playback through an ABORT state. This also adds the 'aborted' output.
//
// Ports:
//   clk        clock, everything on the rising edge
//   rst        synchronous active-high reset
//   load_we    table write strobe (honoured only in IDLE without start)
//   load_addr  table write address
//   load_data  entry = {hold[HOLD_W-1:0], i1, i2}
//   num_steps  entries to play (0..NSTEP), latched at start
//   loop_en    wrap to entry 0 after the last step, latched at start
//   start      begin playback (level, sampled in IDLE)
//   stop       abort playback (PLAY only)
//   o1/o2/err  FSM outputs being monitored
//   i1/i2      drive to the FSM inputs
//   busy       playback active
//   done       one-cycle pulse when playback ends
//   err_cnt    err-high cycles seen during playback (saturating)
//   o1_cnt     o1 rising edges seen during playback (saturating)
//   aborted    (SM_PARA_DRV_ERR_ABORT_EN only) last run ended on err
// -----------------------------------------------------------------------------
module sm_para_drv #(
  parameter int unsigned NSTEP  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [HOLD_W+1:0] load_data,
  input  logic [AW:0]       num_steps,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  input  logic              o1,
  input  logic              o2,
  input  logic              err,
  output logic              i1,
  output logic              i2,
`ifdef SM_PARA_DRV_ERR_ABORT_EN
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  o1_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
  localparam logic [1:0] S_ABORT = 2'd3;
`endif

  localparam logic [AW:0] NUM_ONE = (AW+1)'(1);
  localparam logic [AW:0] NUM_MAX = (AW+1)'(NSTEP);

  // Step table: not reset, written only while idle.
  logic [HOLD_W+1:0] tbl_q [NSTEP];

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [AW:0]       num_q, num_d;
  logic              loop_q, loop_d;
  logic              i1_q, i1_d;
  logic              i2_q, i2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  o1_cnt_q, o1_cnt_d;
  logic              o1_prev_q, o1_prev_d;
  logic              o2_prev_q, o2_prev_d;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  logic [AW:0]       num_clamped;
  logic              last_step;
  logic [AW-1:0]     step_nxt;
  logic [HOLD_W+1:0] first_entry;
  logic [HOLD_W+1:0] nxt_entry;
  logic              table_wr;

  // o2 history is kept for future edge checks and is not consumed yet.
  logic              unused_o2_hist;
  assign unused_o2_hist = o2_prev_q;

  // Counts above the table size would run past the last entry, so clamp them.
  assign num_clamped = (num_steps > NUM_MAX) ? NUM_MAX : num_steps;
  assign last_step   = ({1'b0, step_q} == (num_q - NUM_ONE));
  assign step_nxt    = (last_step) ? '0 : step_q + AW'(1);
  assign first_entry = tbl_q[0];
  assign nxt_entry   = tbl_q[step_nxt];
  assign table_wr    = load_we && !start && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (table_wr) begin
      tbl_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    hold_d    = hold_q;
    num_d     = num_q;
    loop_d    = loop_q;
    i1_d      = 1'b0;
    i2_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_cnt_d = err_cnt_q;
    o1_cnt_d  = o1_cnt_q;
    o1_prev_d = o1;
    o2_prev_d = o2;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
    aborted_d = aborted_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_clamped;
          loop_d    = loop_en;
          step_d    = '0;
          err_cnt_d = '0;
          o1_cnt_d  = '0;
          o1_prev_d = 1'b0;
          o2_prev_d = 1'b0;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
          aborted_d = 1'b0;
`endif
          if (num_clamped == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            hold_d  = '0;
          end else begin
            state_d = S_PLAY;
            busy_d  = 1'b1;
            i1_d    = first_entry[1];
            i2_d    = first_entry[0];
            hold_d  = first_entry[HOLD_W+1:2];
          end
        end
      end

      S_PLAY: begin
        if (err && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (o1 && !o1_prev_q && (o1_cnt_q != '1)) begin
          o1_cnt_d = o1_cnt_q + CNT_W'(1);
        end

        // Priority: stop, then (optionally) err abort, then hold/advance.
        if (stop) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
`ifdef SM_PARA_DRV_ERR_ABORT_EN
        else if (err) begin
          state_d   = S_ABORT;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
`endif
        else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
          busy_d = 1'b1;
          i1_d   = i1_q;
          i2_d   = i2_q;
        end else if (last_step && !loop_q) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          // Next entry is loaded on the same edge, so there is no gap cycle.
          step_d = step_nxt;
          busy_d = 1'b1;
          i1_d   = nxt_entry[1];
          i2_d   = nxt_entry[0];
          hold_d = nxt_entry[HOLD_W+1:2];
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

`ifdef SM_PARA_DRV_ERR_ABORT_EN
      S_ABORT: begin
        state_d = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      hold_q    <= '0;
      num_q     <= '0;
      loop_q    <= 1'b0;
      i1_q      <= 1'b0;
      i2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= '0;
      o1_cnt_q  <= '0;
      o1_prev_q <= 1'b0;
      o2_prev_q <= 1'b0;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      hold_q    <= hold_d;
      num_q     <= num_d;
      loop_q    <= loop_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_cnt_q <= err_cnt_d;
      o1_cnt_q  <= o1_cnt_d;
      o1_prev_q <= o1_prev_d;
      o2_prev_q <= o2_prev_d;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign i1      = i1_q;
  assign i2      = i2_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_cnt_q;
  assign o1_cnt  = o1_cnt_q;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
  assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_sm_para_drv.sv
module tb_sm_para_drv;

  logic       clk;
  logic       rst;
  logic       load_we;
  logic [2:0] load_addr;
  logic [5:0] load_data;
  logic [3:0] num_steps;
  logic       loop_en;
  logic       start;
  logic       stop;
  logic       o1;
  logic       o2;
  logic       err;
  logic       i1;
  logic       i2;
  logic       busy;
  logic       done;
  logic [7:0] err_cnt;
  logic [7:0] o1_cnt;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
  logic       aborted;
`endif

  int n_cmp;
  int n_bad;

  sm_para_drv #(
    .NSTEP (8),
    .AW    (3),
    .HOLD_W(4),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_we  (load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .num_steps(num_steps),
    .loop_en  (loop_en),
    .start    (start),
    .stop     (stop),
    .o1       (o1),
    .o2       (o2),
    .err      (err),
    .i1       (i1),
    .i2       (i2),
`ifdef SM_PARA_DRV_ERR_ABORT_EN
    .aborted  (aborted),
`endif
    .busy     (busy),
    .done     (done),
    .err_cnt  (err_cnt),
    .o1_cnt   (o1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [5:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outs got %b exp 0000", {busy, done, i1, i2});
    end
    n_cmp++;
    if (err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_err_cnt got %0d exp 0", err_cnt);
    end
    n_cmp++;
    if (o1_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_o1_cnt got %0d exp 0", o1_cnt);
    end
`ifdef SM_PARA_DRV_ERR_ABORT_EN
    n_cmp++;
    if (aborted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_aborted got %b exp 0", aborted);
    end
`endif
  endtask

  task automatic test_basic();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
    load(3'd0, {4'd0, 2'b10});
    load(3'd1, {4'd2, 2'b11});
    load(3'd2, {4'd1, 2'b01});
    num_steps = 4'd3;
    loop_en   = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if ({busy, done, i1, i2} !== {2'b10, exp_seq[c]}) begin
        n_bad++;
        $display("FAIL basic_play c=%0d got %b exp %b", c, {busy, done, i1, i2}, {2'b10, exp_seq[c]});
      end
      tick();
    end
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0100) begin
      n_bad++;
      $display("FAIL basic_fin got %b exp 0100", {busy, done, i1, i2});
    end
    tick();
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_idle got %b exp 0000", {busy, done, i1, i2});
    end
  endtask

  task automatic test_loop_stop();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
    num_steps = 4'd3;
    loop_en   = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 13; c++) begin
      n_cmp++;
      if ({busy, done, i1, i2} !== {2'b10, exp_seq[c % 6]}) begin
        n_bad++;
        $display("FAIL loop_play c=%0d got %b exp %b", c, {busy, done, i1, i2}, {2'b10, exp_seq[c % 6]});
      end
      if (c == 12) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0100) begin
      n_bad++;
      $display("FAIL loop_stop_fin got %b exp 0100", {busy, done, i1, i2});
    end
    tick();
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL loop_stop_idle got %b exp 0000", {busy, done, i1, i2});
    end
  endtask

  task automatic test_zero_steps();
    num_steps = 4'd0;
    loop_en   = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0100) begin
      n_bad++;
      $display("FAIL zero_fin got %b exp 0100", {busy, done, i1, i2});
    end
    tick();
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL zero_idle got %b exp 0000", {busy, done, i1, i2});
    end
  endtask

  task automatic test_monitor();
`ifdef SM_PARA_DRV_ERR_ABORT_EN
    int ncyc = 4;
`else
    int ncyc = 12;
`endif
    load(3'd0, {4'd0, 2'b00});
    load(3'd1, {4'd0, 2'b11});
    num_steps = 4'd2;
    loop_en   = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      n_cmp++;
      if ({busy, done, i1, i2} !== ((c % 2 == 0) ? 4'b1000 : 4'b1011)) begin
        n_bad++;
        $display("FAIL mon_play c=%0d got %b exp %b", c, {busy, done, i1, i2},
                 ((c % 2 == 0) ? 4'b1000 : 4'b1011));
      end
      err = (c >= 3 && c <= 5);
      o1  = (c == 1 || c == 3 || c == 5 || c == 7);
      tick();
    end
    err = 1'b0;
    o1  = 1'b0;
`ifdef SM_PARA_DRV_ERR_ABORT_EN
    n_cmp++;
    if ({busy, done, i1, i2, aborted} !== 5'b01001) begin
      n_bad++;
      $display("FAIL mon_abort got %b exp 01001", {busy, done, i1, i2, aborted});
    end
    n_cmp++;
    if (err_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL mon_abort_err_cnt got %0d exp 1", err_cnt);
    end
    n_cmp++;
    if (o1_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL mon_abort_o1_cnt got %0d exp 2", o1_cnt);
    end
    tick();
    n_cmp++;
    if ({busy, done, aborted, err_cnt} !== {3'b001, 8'd1}) begin
      n_bad++;
      $display("FAIL mon_abort_hold got %b exp %b", {busy, done, aborted, err_cnt}, {3'b001, 8'd1});
    end
`else
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0100) begin
      n_bad++;
      $display("FAIL mon_fin got %b exp 0100", {busy, done, i1, i2});
    end
    n_cmp++;
    if (err_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL mon_err_cnt got %0d exp 3", err_cnt);
    end
    n_cmp++;
    if (o1_cnt !== 8'd4) begin
      n_bad++;
      $display("FAIL mon_o1_cnt got %0d exp 4", o1_cnt);
    end
    tick();
    n_cmp++;
    if ({err_cnt, o1_cnt} !== {8'd3, 8'd4}) begin
      n_bad++;
      $display("FAIL mon_hold got %0d/%0d exp 3/4", err_cnt, o1_cnt);
    end
`endif
  endtask

`ifndef SM_PARA_DRV_ERR_ABORT_EN
  task automatic test_saturation();
    num_steps = 4'd2;
    loop_en   = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({err_cnt, o1_cnt} !== 16'd0) begin
      n_bad++;
      $display("FAIL sat_clear_at_start got %0d/%0d exp 0/0", err_cnt, o1_cnt);
    end
    err = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    err  = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_err_cnt got %0d exp 255", err_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_busy_write_reset();
    load(3'd0, {4'd0, 2'b10});
    num_steps = 4'd2;
    loop_en   = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    load_we   = 1'b1;
    load_addr = 3'd0;
    load_data = {4'd0, 2'b01};
    tick();
    load_we = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_mid_outs got %b exp 0000", {busy, done, i1, i2});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mid_no_done got %b exp 00", {busy, done});
    end
    // Write presented together with start must also be ignored.
    num_steps = 4'd1;
    loop_en   = 1'b0;
    start     = 1'b1;
    load_we   = 1'b1;
    load_addr = 3'd0;
    load_data = {4'd0, 2'b01};
    tick();
    start   = 1'b0;
    load_we = 1'b0;
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b1010) begin
      n_bad++;
      $display("FAIL busy_write_ignored got %b exp 1010", {busy, done, i1, i2});
    end
    tick();
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_step_fin got %b exp 0100", {busy, done, i1, i2});
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, done, i1, i2} !== 4'b1010) begin
      n_bad++;
      $display("FAIL start_write_ignored got %b exp 1010", {busy, done, i1, i2});
    end
    tick();
    tick();
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    num_steps = '0;
    loop_en   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    o1        = 1'b0;
    o2        = 1'b0;
    err       = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_loop_stop();
    test_zero_steps();
    test_monitor();
`ifndef SM_PARA_DRV_ERR_ABORT_EN
    test_saturation();
`endif
    test_busy_write_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
